// File: rtl/pn_stack_eval.sv
// rtl/pn_stack_eval.sv - Polish-notation expression evaluator with token buffer and hardware stack
module pn_stack_eval #(
  parameter int DATA_W  = 32,
  parameter int IN_W    = 3,
  parameter int MAX_TOK = 16,
  parameter int STACK_D = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mode,
  input  logic              operator,
  input  logic [IN_W-1:0]   in,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int CW = $clog2(MAX_TOK + 1);
  localparam int IW = (MAX_TOK > 1) ? $clog2(MAX_TOK) : 1;
  localparam int SW = $clog2(STACK_D + 1);
  localparam int KW = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL} state_t;

  state_t                   state;
  logic [IN_W:0]            tok_buf [MAX_TOK];
  logic signed [DATA_W-1:0] stk [STACK_D];
  logic [CW-1:0]            count, step;
  logic [SW-1:0]            sp;
  logic                     mode_q, ovf;

  logic [IW-1:0]            idx;
  logic [IN_W:0]            tok;
  logic                     is_op, last;
  logic [IN_W-1:0]          val;
  logic signed [DATA_W-1:0] a, b, sum, alu, res_val;
  logic [SW-1:0]            new_sp;
  logic [1:0]               tok_code, fin_code;

  assign in_ready = (state != EVAL);

  // Postfix scans forward, prefix scans backward; operand order flips with it.
  always_comb begin
    idx      = mode_q ? IW'(step) : IW'(count - CW'(1) - step);
    tok      = tok_buf[idx];
    is_op    = tok[IN_W];
    val      = tok[IN_W-1:0];
    a        = mode_q ? stk[KW'(sp - SW'(2))] : stk[KW'(sp - SW'(1))];
    b        = mode_q ? stk[KW'(sp - SW'(1))] : stk[KW'(sp - SW'(2))];
    sum      = a + b;
    alu      = sum;
    case (val[2:0])
      3'd1:    alu = a - b;
      3'd2:    alu = a * b;
      3'd3:    alu = sum[DATA_W-1] ? -sum : sum;
      3'd4:    alu = (a > b) ? a : b;
      3'd5:    alu = (a < b) ? a : b;
      default: alu = sum;
    endcase
    res_val  = is_op ? alu : {{(DATA_W-IN_W){1'b0}}, val};
    new_sp   = is_op ? sp - SW'(1) : sp + SW'(1);
    last     = (step == count - CW'(1));
    tok_code = 2'd0;
    if (is_op) begin
      if (sp < SW'(2))
        tok_code = 2'd1;
      else if (val >= IN_W'(6))
        tok_code = 2'd3;
    end else if (sp == SW'(STACK_D)) begin
      tok_code = 2'd2;
    end
    fin_code = (tok_code != 2'd0) ? tok_code :
               (last && new_sp != SW'(1)) ? 2'd3 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      sp        <= '0;
      count     <= '0;
      step      <= '0;
      mode_q    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          mode_q     <= mode;
          tok_buf[0] <= {operator, in};
          count      <= CW'(1);
          ovf        <= 1'b0;
          state      <= LOAD;
        end
        LOAD: if (in_valid) begin
          if (count == CW'(MAX_TOK)) begin
            ovf <= 1'b1;
          end else begin
            tok_buf[IW'(count)] <= {operator, in};
            count               <= count + CW'(1);
          end
        end else begin
          step  <= '0;
          sp    <= '0;
          state <= EVAL;
        end
        EVAL: begin
          // Any error aborts immediately; the stack contents are simply abandoned.
          if (ovf || fin_code != 2'd0) begin
            out_valid <= 1'b1;
            out       <= '0;
            err       <= 1'b1;
            err_code  <= ovf ? 2'd2 : fin_code;
            state     <= IDLE;
          end else begin
            stk[is_op ? KW'(sp - SW'(2)) : KW'(sp)] <= res_val;
            sp   <= new_sp;
            step <= step + CW'(1);
            if (last) begin
              out_valid <= 1'b1;
              out       <= res_val;
              err       <= 1'b0;
              err_code  <= 2'd0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pn_stack_eval.sv
// tb/tb_pn_stack_eval.sv - scoreboard bench for pn_stack_eval (32-bit and 8-bit instances)
module tb_pn_stack_eval;

  typedef struct {
    logic [31:0] val;
    logic [1:0]  code;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iva = 1'b0, iv8 = 1'b0, mode = 1'b0, operator = 1'b0;
  logic [2:0]  tok_in = '0;
  logic        in_ready, out_valid, err;
  logic [31:0] out;
  logic [1:0]  err_code;
  logic        in_ready8, out_valid8, err8;
  logic [7:0]  out8;
  logic [1:0]  err_code8;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t exp_q8[$];
  logic [3:0] tq[$];

  pn_stack_eval u_dut (
    .clk(clk), .rst(rst), .in_valid(iva), .mode(mode), .operator(operator), .in(tok_in),
    .in_ready(in_ready), .out_valid(out_valid), .out(out), .err(err), .err_code(err_code)
  );

  pn_stack_eval #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .mode(mode), .operator(operator), .in(tok_in),
    .in_ready(in_ready8), .out_valid(out_valid8), .out(out8), .err(err8), .err_code(err_code8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic d(input int v); tq.push_back({1'b0, 3'(v)}); endtask
  task automatic o(input int v); tq.push_back({1'b1, 3'(v)}); endtask

  // mode is inverted after the first token to show only the first one is latched
  task automatic send(input bit sel8, input bit m, input logic [31:0] ev,
                      input logic [1:0] ec, input int lat);
    exp_t e;
    foreach (tq[i]) begin
      if (sel8) iv8 = 1'b1; else iva = 1'b1;
      mode     = (i == 0) ? m : ~m;
      operator = tq[i][3];
      tok_in   = tq[i][2:0];
      @(posedge clk); #1;
      if (i == 0) begin
        e.val = ev; e.code = ec; e.due = cyc + lat;
        if (sel8) exp_q8.push_back(e); else exp_q.push_back(e);
      end
    end
    iva = 1'b0; iv8 = 1'b0; operator = 1'b0; tok_in = '0;
    @(posedge clk); #1;
    chk(sel8 ? "in_ready8_low" : "in_ready_low", 32'(sel8 ? in_ready8 : in_ready), 32'd0);
    tq.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || exp_q8.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0 || exp_q8.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: %0d/%0d results pending, expected 0", exp_q.size(), exp_q8.size());
      exp_q.delete(); exp_q8.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (out %0h)", out);
      end else begin
        e = exp_q.pop_front();
        chk("out", out, e.val);
        chk("err_code", 32'(err_code), 32'(e.code));
        chk("err", 32'(err), 32'(e.code != 2'd0));
        chk("latency", cyc, e.due);
      end
    end
    if (out_valid8) begin
      if (exp_q8.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_out_valid8: got 1 expected 0 (out %0h)", out8);
      end else begin
        e = exp_q8.pop_front();
        chk("out8", 32'(out8), e.val);
        chk("err_code8", 32'(err_code8), 32'(e.code));
        chk("latency8", cyc, e.due);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    d(3); d(4); o(0); d(2); o(2);   send(0, 1, 32'd14, 2'd0, 10); drain();
    o(1); o(2); d(3); d(4); d(2);   send(0, 0, 32'd10, 2'd0, 10); drain();
    o(1); d(2); d(5);               send(0, 0, -32'sd3, 2'd0, 6);  drain();
    o(4); o(1); d(2); d(5); d(2);   send(0, 0, 32'd2, 2'd0, 10);   drain();
    o(5); o(1); d(2); d(5); d(2);   send(0, 0, -32'sd3, 2'd0, 10); drain();
    o(3); o(1); d(2); d(5); d(1);   send(0, 0, 32'd2, 2'd0, 10);   drain();
    d(5);                           send(0, 1, 32'd5, 2'd0, 2);    drain();

    d(3); o(0);                     send(0, 1, 32'd0, 2'd1, 4);    drain();
    d(3); d(4);                     send(0, 1, 32'd0, 2'd3, 4);    drain();
    d(3); o(6);                     send(0, 1, 32'd0, 2'd1, 4);    drain();
    d(1); d(2); o(7);               send(0, 1, 32'd0, 2'd3, 6);    drain();
    for (int i = 0; i < 9; i++) d(i % 8);
    send(0, 1, 32'd0, 2'd2, 18); drain();
    for (int i = 0; i < 17; i++) d(1);
    send(0, 1, 32'd0, 2'd2, 18); drain();

    d(7); d(7); o(2); d(7); o(2); d(7); o(2);
    send(1, 1, 32'd97, 2'd0, 14); drain();

    d(3); d(4); o(0); d(2); o(2);   send(0, 1, 32'd14, 2'd0, 10);
    for (int i = 0; i < 50 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("b2b_out_valid", 32'(out_valid), 32'd1);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);
    d(6); d(7); o(1);               send(0, 1, -32'sd1, 2'd0, 6);  drain();

    iva = 1'b1; mode = 1'b1; operator = 1'b0; tok_in = 3'd1;
    @(posedge clk); #1;
    tok_in = 3'd2;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; iva = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out", out, 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_err_code", 32'(err_code), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    d(2); d(3); o(2);               send(0, 1, 32'd6, 2'd0, 6);    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pn_stack_eval.md
# pn_stack_eval

Parametrised Polish-notation expression evaluator: buffers a burst of operand/operator tokens, then evaluates it with a hardware stack in prefix or postfix order, one token per cycle. It is the general successor to the fixed 12-token, 32-bit PN block, adding configurable width and depth, extra operators, an input back-pressure signal, and error reporting. It sits between the token source and the result consumer in the calculator datapath.

## Interface
- DATA_W, 32: result and stack-entry width (signed, two's complement)
- IN_W, 3: token payload width; operands are unsigned and zero-extended
- MAX_TOK, 16: token buffer depth (max expression length)
- STACK_D, 8: evaluation stack depth
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous and active-high; one clock, no other clock domains
- in_valid  in  1  token strobe; a contiguous high run is one expression
- mode  in  1  0 = prefix, 1 = postfix; sampled with the first token only
- operator  in  1  1 = `in` is an opcode, 0 = `in` is an operand
- in  in  IN_W  token payload
- in_ready  out  1  high in IDLE/LOAD; tokens offered while low are ignored
- out_valid  out  1  one-cycle result strobe
- out  out  DATA_W  signed result; 0 when err is set
- err  out  1  expression error, valid with out_valid
- err_code  out  2  0 none, 1 stack underflow, 2 overflow (stack or token buffer), 3 malformed (illegal opcode or final depth ≠ 1)

## Operation
- FSM: IDLE → LOAD → EVAL → IDLE.
- IDLE: the first in_valid latches `mode` and stores token 0. Next state is LOAD.
- LOAD: each in_valid cycle stores one token. When in_valid is low, the next state is EVAL.
- Tokens beyond MAX_TOK are dropped and the overflow flag is set. In that case EVAL is skipped and the block reports err_code 2 on the next edge.
- EVAL scans the buffer one token per cycle.
  - Postfix: scan index 0 → N-1. The operator pops b (top), then a.
  - Prefix: scan index N-1 → 0. The operator pops a (top), then b.
  - Both orders push `a op b`.
- Operand tokens push zero-extended `in`.
- Opcodes: 0 a+b, 1 a−b, 2 a*b (low DATA_W bits), 3 |a+b|, 4 max(a,b), 5 min(a,b), 6/7 illegal.
- All arithmetic wraps modulo 2^DATA_W; comparisons are signed. |−2^(DATA_W-1)| returns −2^(DATA_W-1).
- Error handling:
  - Operator with depth < 2 → code 1.
  - Push at depth STACK_D → code 2.
  - Illegal opcode → code 3.
  - On the last token, depth ≠ 1 → code 3.
  - The first error wins. Evaluation aborts on the faulting token and the stack is discarded.
- Result: `out` = stack[0] on success, 0 on error. `err` = (err_code ≠ 0).
- `mode`/`operator` changes mid-burst have no effect on the latched mode.

## Timing
- Reset values: out_valid 0, out 0, err 0, err_code 0, in_ready 1, FSM IDLE, stack pointer 0, token count 0.
- rst is honoured at any state. It discards a partial expression and any pending result; no out_valid follows.
- Latency: first token sampled at edge E0, N tokens (N ≤ MAX_TOK). in_valid low is sampled at E(N) and EVAL processes token k at edge E(N+1+k).
  - Clean result: out/err/out_valid are registered at E(2N), so out_valid is high for the cycle after E(2N).
  - Error at token k: registered at E(N+1+k).
  - Buffer overflow: registered at the edge after in_valid is first sampled low.
- out_valid is high for exactly one cycle. `out` and err_code hold until the next out_valid or reset.
- in_ready is low from E(N) until the result edge. It returns high in the same cycle out_valid is high, so a new burst may start there (back-to-back).
- N = 1 (single operand) is valid and yields that operand at E(2).

## Test plan
- Postfix, defaults: tokens 3, 4, op0, 2, op2 → out = 14, err = 0, out_valid in the cycle after E(10).
- Prefix: op1, op2, 3, 4, 2 → (3*4)−2 = 10. Prefix: op1, 2, 5 → −3. Prefix op4 / op5 on (−3, 2) via nested op1 → max 2, min −3.
- Errors: postfix 3, op0 → err_code 1, out 0. Postfix 3, 4 → err_code 3. Postfix 3, op6 → err_code 1 (underflow detected before the opcode check). Postfix 1, 2, op7 → err_code 3.
- Overflow: STACK_D = 8, postfix 9 operands → err_code 2 on the 9th push. MAX_TOK = 16, 17-token burst → err_code 2, in_ready low until reported.
- Wrap: DATA_W = 8, postfix 7, 7, op2, 7, op2, 7, op2 → 2401 mod 256 = 97.
- Reset and throughput: rst asserted mid-LOAD → no out_valid, all outputs at reset values. A burst started in the out_valid cycle evaluates correctly with no lost tokens.
